// File: rtl/rx_uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, setup-word layout, break multiple.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rx_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    // Bit positions inside the 30-bit setup word
    localparam int SETUP_W        = 30;
    localparam int SETUP_BITS_HI  = 29;
    localparam int SETUP_BITS_LO  = 28;
    localparam int SETUP_TWO_STOP = 27;
    localparam int SETUP_PAR_EN   = 26;
    localparam int SETUP_PAR_FIX  = 25;
    localparam int SETUP_PAR_POL  = 24;
    localparam int SETUP_CPB_HI   = 23;
    localparam int CPB_W          = 24;

    // Line must stay low this many bit times before it is called a break
    localparam int BREAK_MULT = 12;

    // Word length from the two-bit selector: 00=8, 01=7, 10=6, 11=5
    function automatic logic [3:0] data_bits(input logic [1:0] sel);
        return 4'd8 - {2'b00, sel};
    endfunction

    // The half-bit offset needs at least two clocks per baud to be meaningful
    function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
        return (cpb < 24'd2) ? 24'd2 : cpb;
    endfunction

endpackage

// File: rtl/rx_uart_sync.sv
// Multi-flop synchronizer bringing the asynchronous serial line into the i_clk domain.
// Latency: SYNC_STAGES cycles from i_d to o_q.
// Backpressure: none; free-running shift chain, reset to idle-high.
module rx_uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the line through the chain; reset to 1 so a held-low line never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_uart.sv
// UART receiver: mid-bit sampling, 5..8 data bits, optional parity, 1/2 stops; break detect with RX_UART_BREAK_EN.
// Latency: o_wr one cycle after the last stop-bit sample (sample points are S+CPB/2+n*CPB).
// Backpressure: none; o_wr is a one-cycle strobe, results hold until the next strobe.
module rx_uart
    import rx_uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [29:0] i_setup,
    input  logic        i_uart,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_break,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_ck_uart
);

    // Offsets of the latched mode bits (setup[29:24] stored as mode_q[5:0])
    localparam int M_BITS_HI  = SETUP_BITS_HI  - SETUP_PAR_POL;
    localparam int M_BITS_LO  = SETUP_BITS_LO  - SETUP_PAR_POL;
    localparam int M_TWO_STOP = SETUP_TWO_STOP - SETUP_PAR_POL;
    localparam int M_PAR_EN   = SETUP_PAR_EN   - SETUP_PAR_POL;
    localparam int M_PAR_FIX  = SETUP_PAR_FIX  - SETUP_PAR_POL;
    localparam int M_PAR_POL  = 0;

    logic ck;

    rx_uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_uart),
        .o_q     (ck)
    );

    assign o_ck_uart = ck;

    rx_state_t         state_q, state_d;
    logic [5:0]        mode_q;
    logic [CPB_W-1:0]  cpb_q;
    logic [CPB_W-1:0]  baud_cnt;
    logic [CPB_W-1:0]  cpb_in;
    logic [2:0]        bit_idx;
    logic [7:0]        data_q;
    logic              par_acc;
    logic              par_bit_q;
    logic              ferr_acc;
    logic              armed_q;

    logic tick, last_data, two_stop, par_en, perr_calc;
    logic start_frame, glitch, sample_data, sample_par, sample_stop, frame_done;

    assign cpb_in    = clamp_cpb(i_setup[SETUP_CPB_HI:0]);
    assign tick      = (baud_cnt == '0);
    assign two_stop  = mode_q[M_TWO_STOP];
    assign par_en    = mode_q[M_PAR_EN];
    assign last_data = ({1'b0, bit_idx} == (data_bits(mode_q[M_BITS_HI:M_BITS_LO]) - 4'd1));

    // par_acc holds the XOR of data and parity bits: 1 means an odd number of ones
    assign perr_calc = par_en & (mode_q[M_PAR_FIX] ? (par_bit_q != mode_q[M_PAR_POL])
                                                   : (mode_q[M_PAR_POL] ? par_acc : ~par_acc));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance one field per baud tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (armed_q && !ck) state_d = ST_START;
            ST_START:  if (tick) state_d = ck ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && last_data) state_d = par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (tick) state_d = ST_STOP1;
            ST_STOP1:  if (tick) state_d = two_stop ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode: which sample or frame event happens this cycle
    always_comb begin
        start_frame = 1'b0;
        glitch      = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE:   start_frame = armed_q & ~ck;
            ST_START:  glitch      = tick & ck;
            ST_DATA:   sample_data = tick;
            ST_PARITY: sample_par  = tick;
            ST_STOP1: begin
                sample_stop = tick;
                frame_done  = tick & ~two_stop;
            end
            ST_STOP2: begin
                sample_stop = tick;
                frame_done  = tick;
            end
            default: ;
        endcase
    end

    // Datapath: baud counter, bit capture, error accumulation, result registers, arming
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q       <= '0;
            cpb_q        <= 24'd2;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            data_q       <= '0;
            par_acc      <= 1'b0;
            par_bit_q    <= 1'b0;
            ferr_acc     <= 1'b0;
            armed_q      <= 1'b0;
            o_wr         <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_wr <= frame_done;

            if (start_frame) begin
                // Freeze the frame format; first tick lands half a bit in
                mode_q    <= i_setup[SETUP_BITS_HI:SETUP_PAR_POL];
                cpb_q     <= cpb_in;
                baud_cnt  <= (cpb_in >> 1) - 24'd1;
                bit_idx   <= '0;
                data_q    <= '0;
                par_acc   <= 1'b0;
                par_bit_q <= 1'b0;
                ferr_acc  <= 1'b0;
                armed_q   <= 1'b0;
            end else if (state_q != ST_IDLE) begin
                // Reload on the tick so the counter never wraps
                baud_cnt <= tick ? (cpb_q - 24'd1) : (baud_cnt - 24'd1);
            end else if (ck) begin
                armed_q <= 1'b1;
            end

            if (glitch) begin
                armed_q <= 1'b1;
            end

            if (sample_data) begin
                data_q[bit_idx] <= ck;
                bit_idx         <= bit_idx + 3'd1;
                par_acc         <= par_acc ^ ck;
            end

            if (sample_par) begin
                par_bit_q <= ck;
                par_acc   <= par_acc ^ ck;
            end

            if (sample_stop && !ck) begin
                ferr_acc <= 1'b1;
            end

            if (frame_done) begin
                o_data       <= data_q;
                o_parity_err <= perr_calc;
                o_frame_err  <= ferr_acc | ~ck;
                // A low final stop (framing error or break) must see the line high before the next start
                armed_q      <= ck;
            end
        end
    end

`ifdef RX_UART_BREAK_EN
    logic [27:0] low_cnt;
    logic [27:0] brk_thr;

    assign brk_thr = {4'd0, cpb_q} * 28'(BREAK_MULT);

    // Count consecutive low cycles; flag a break once the count reaches BREAK_MULT bit times
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            low_cnt <= '0;
            o_break <= 1'b0;
        end else if (ck) begin
            low_cnt <= '0;
            o_break <= 1'b0;
        end else begin
            if (low_cnt != '1) begin
                low_cnt <= low_cnt + 28'd1;
            end
            if (low_cnt >= (brk_thr - 28'd1)) begin
                o_break <= 1'b1;
            end
        end
    end
`else
    assign o_break = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: scoreboard of expected words checked on each o_wr strobe.
// Latency: expected o_wr cycle computed from the drive cycle and frame format.
// Backpressure: n/a.
module tb_rx_uart;
    import rx_uart_pkg::*;

    localparam int SYNC = 2;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_uart  = 1'b1;
    logic [29:0] i_setup = '0;
    logic        o_wr, o_break, o_parity_err, o_frame_err, o_ck_uart;
    logic [7:0]  o_data;

    rx_uart #(.SYNC_STAGES(SYNC)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_setup      (i_setup),
        .i_uart       (i_uart),
        .o_wr         (o_wr),
        .o_data       (o_data),
        .o_break      (o_break),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_ck_uart    (o_ck_uart)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;

    // Scoreboard monitor: every o_wr must match the oldest expected word and cycle
    always @(negedge i_clk) begin
        if (o_wr === 1'b1) begin
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr cyc=%0d data=%0h pe=%0b fe=%0b", cyc, o_data, o_parity_err, o_frame_err);
            end else begin
                mon_e = sb.pop_front();
                if (o_data !== mon_e.d || o_parity_err !== mon_e.pe || o_frame_err !== mon_e.fe) begin
                    errors++;
                    $display("FAIL word got data=%0h pe=%0b fe=%0b expected data=%0h pe=%0b fe=%0b",
                             o_data, o_parity_err, o_frame_err, mon_e.d, mon_e.pe, mon_e.fe);
                end
                checks++;
                if (cyc !== mon_e.at) begin
                    errors++;
                    $display("FAIL wr_cycle got %0d expected %0d", cyc, mon_e.at);
                end
            end
        end
    end

    function automatic logic [29:0] mk(input logic [1:0] sel, input logic two, input logic pen,
                                       input logic fix, input logic pol, input int cpb);
        return {sel, two, pen, fix, pol, cpb[23:0]};
    endfunction

    function automatic int lat(input int nbits, input int par, input int nstop, input int cpb);
        return SYNC + cpb / 2 + (nbits + par + nstop) * cpb + 1;
    endfunction

    // Reference parity check: even (pol=1) wants an even count of ones over data+parity
    function automatic logic exp_perr(input logic [7:0] d, input logic fix, input logic pol, input logic pbit);
        logic ones;
        ones = (^d) ^ pbit;
        if (fix) return pbit != pol;
        return pol ? ones : ~ones;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int nbits, input logic par_on, input logic par_bit,
                        input int nstop, input logic stop_val, input int cpb);
        logic [11:0] b;
        int n;
        b = '0;
        for (int k = 0; k < nbits; k++) b[1+k] = d[k];
        n = 1 + nbits;
        if (par_on) begin
            b[n] = par_bit;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            b[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            i_uart = b[i];
            tick(cpb);
        end
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while (sb.size() != 0 && w < budget) begin
            @(posedge i_clk);
            w++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        i_uart  = 1'b0;
        i_reset = 1'b1;
        tick(1);
        checks += 6;
        if (o_wr !== 1'b0)         begin errors++; $display("FAIL rst_wr got %b expected 0", o_wr); end
        if (o_data !== 8'h00)      begin errors++; $display("FAIL rst_data got %h expected 00", o_data); end
        if (o_break !== 1'b0)      begin errors++; $display("FAIL rst_break got %b expected 0", o_break); end
        if (o_parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b expected 0", o_parity_err); end
        if (o_frame_err !== 1'b0)  begin errors++; $display("FAIL rst_ferr got %b expected 0", o_frame_err); end
        if (o_ck_uart !== 1'b1)    begin errors++; $display("FAIL rst_ck got %b expected 1", o_ck_uart); end
        i_uart  = 1'b1;
        i_reset = 1'b0;
        tick(5);
    endtask

    task automatic test_8n1();
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        tick(2);
        sb.push_back('{8'h55, 1'b0, 1'b0, cyc + lat(8, 0, 1, 8)});
        send(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, 8);
        sb.push_back('{8'hA3, 1'b0, 1'b0, cyc + lat(8, 0, 1, 8)});
        send(8'hA3, 8, 1'b0, 1'b0, 1, 1'b1, 8);
        wait_drain(200);
        tick(4);
    endtask

    task automatic test_parity();
        logic [7:0] dv [2];
        logic [1:0] modes [4];
        logic       pb;
        dv[0] = 8'h41; dv[1] = 8'h2A;
        modes[0] = 2'b01;  // free parity, even
        modes[1] = 2'b00;  // free parity, odd
        modes[2] = 2'b11;  // stick 1
        modes[3] = 2'b10;  // stick 0
        for (int m = 0; m < 4; m++) begin
            i_setup = mk(2'b01, 1'b0, 1'b1, modes[m][1], modes[m][0], 8);
            for (int p = 0; p < 2; p++) begin
                for (int j = 0; j < 2; j++) begin
                    pb = p[0];
                    sb.push_back('{dv[j], exp_perr(dv[j], modes[m][1], modes[m][0], pb), 1'b0,
                                   cyc + lat(7, 1, 1, 8)});
                    send(dv[j], 7, 1'b1, pb, 1, 1'b1, 8);
                end
            end
        end
        wait_drain(200);
        tick(4);
    endtask

    task automatic test_frame_err();
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        tick(2);
        sb.push_back('{8'hC3, 1'b0, 1'b1, cyc + lat(8, 0, 1, 8)});
        send(8'hC3, 8, 1'b0, 1'b0, 1, 1'b0, 8);
        tick(90);
        checks += 2;
        if (o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_hold got %b expected 1", o_frame_err); end
        if (o_data !== 8'hC3)     begin errors++; $display("FAIL data_hold got %h expected c3", o_data); end
        i_uart = 1'b1;
        tick(4);
        sb.push_back('{8'h3C, 1'b0, 1'b0, cyc + lat(8, 0, 1, 8)});
        send(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 8);
        wait_drain(200);
        tick(4);
    endtask

    task automatic test_glitch();
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        tick(2);
        i_uart = 1'b0;
        tick(3);
        i_uart = 1'b1;
        tick(100);
        checks++;
        if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL glitch_state got %0d expected %0d", dut.state_q, ST_IDLE); end
        sb.push_back('{8'h5A, 1'b0, 1'b0, cyc + lat(8, 0, 1, 16)});
        send(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        wait_drain(300);
        tick(4);
    endtask

    task automatic test_break();
        logic exp_brk;
`ifdef RX_UART_BREAK_EN
        exp_brk = 1'b1;
`else
        exp_brk = 1'b0;
`endif
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        tick(2);
        sb.push_back('{8'h00, 1'b0, 1'b1, cyc + lat(8, 0, 1, 8)});
        i_uart = 1'b0;
        tick(80);
        checks++;
        if (o_break !== 1'b0) begin errors++; $display("FAIL break_early got %b expected 0", o_break); end
        tick(25);
        checks++;
        if (o_break !== exp_brk) begin errors++; $display("FAIL break_on got %b expected %b", o_break, exp_brk); end
        tick(55);
        i_uart = 1'b1;
        tick(2);
        checks++;
        if (o_break !== exp_brk) begin errors++; $display("FAIL break_hold got %b expected %b", o_break, exp_brk); end
        tick(1);
        checks++;
        if (o_break !== 1'b0) begin errors++; $display("FAIL break_off got %b expected 0", o_break); end
        wait_drain(50);
        tick(20);
    endtask

    task automatic test_5bit_2stop_reset();
        int wr0;
        i_setup = mk(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        tick(2);
        sb.push_back('{8'h1F, 1'b0, 1'b0, cyc + lat(5, 0, 2, 8)});
        send(8'h1F, 5, 1'b0, 1'b0, 2, 1'b1, 8);
        wait_drain(100);
        tick(4);
        wr0 = wr_count;
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        i_uart  = 1'b0;
        tick(30);
        i_reset = 1'b1;
        i_uart  = 1'b1;
        tick(1);
        i_reset = 1'b0;
        tick(200);
        checks += 2;
        if (wr_count !== wr0) begin errors++; $display("FAIL reset_abort wr got %0d expected %0d", wr_count, wr0); end
        if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", o_data); end
    endtask

    task automatic test_back_to_back();
        i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        tick(2);
        fork
            begin
                sb.push_back('{8'h96, 1'b0, 1'b0, cyc + lat(8, 0, 1, 8)});
                send(8'h96, 8, 1'b0, 1'b0, 1, 1'b1, 8);
                sb.push_back('{8'h69, 1'b0, 1'b0, cyc + lat(8, 0, 1, 8)});
                send(8'h69, 8, 1'b0, 1'b0, 1, 1'b1, 8);
            end
            begin
                tick(10);
                i_setup = mk(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 3);
                tick(50);
                i_setup = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
            end
        join
        wait_drain(200);
        tick(4);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_break();
        test_back_to_back();
        test_5bit_2stop_reset();
        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
